// File: rtl/bin_to_bcd_serial_pkg.sv
// Shared definitions for the binary-to-BCD display path: FSM state encoding,
// BCD digit constants and the display-range helper.
package bin_to_bcd_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  // Largest value representable in the given number of decimal digits.
  function automatic int max_val(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit of the shift-and-add-3 step: digits of 5 or more get +3 so
// the following left shift carries correctly into the next decade.
module bcd_digit_adjust
  import bin_to_bcd_serial_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= ADJ_THRESH) begin
      dout = din + ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter (one bit per clock) with start/done handshake;
// inputs above the display range saturate to all nines and flag ovf.
//
// state | meaning
// IDLE  | waiting for start; operand and overflow captured on acceptance
// SHIFT | BIN_W adjust-and-shift steps through the working register
// DONE  | result and overflow flag copied to the outputs, done pulse follows
module bin_to_bcd_serial
  import bin_to_bcd_serial_pkg::*;
#(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          ovf
);

  localparam int BCD_W   = BCD_DIGIT_W * DIGITS;
  localparam int WORK_W  = BCD_W + BIN_W;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int MAX_VAL = max_val(DIGITS);
  // When the display range covers every input code, saturation can never occur.
  localparam bit CAN_OVF = (MAX_VAL < (1 << BIN_W));
  localparam logic [BIN_W-1:0] MAX_OPND = BIN_W'(MAX_VAL);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [WORK_W-1:0]   work;
  logic [WORK_W-1:0]   work_adj;
  logic                ovf_pend;
  logic [31:0]         bin_ext;
  logic                over;
  logic [BIN_W-1:0]    operand;

  assign bin_ext = 32'(bin);
  assign over    = CAN_OVF && (bin_ext > 32'(MAX_VAL));
  assign operand = over ? MAX_OPND : bin;

  assign work_adj[BIN_W-1:0] = work[BIN_W-1:0];

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (work[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (work_adj[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      work     <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // Registered status lags the state by one edge, so busy also covers the done cycle.
      done <= (state == DONE);
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            work     <= {{BCD_W{1'b0}}, operand};
            cnt      <= CNT_W'(BIN_W);
            ovf_pend <= over;
          end
        end
        SHIFT: begin
          work <= {work_adj[WORK_W-2:0], 1'b0};
          cnt  <= cnt - CNT_W'(1);
        end
        DONE: begin
          bcd <= work[WORK_W-1:BIN_W];
          ovf <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

endmodule
